// File: rtl/decompose_hint_mem.sv
// Multi-polynomial hint/z bit buffer with swept zeroize and running popcounts.
// Optional write-through read bypass: define DECOMPOSE_HINT_MEM_RDBYPASS_EN.

// Saturating accumulator used for each per-poly counter and for the total.
module hint_sat_cnt #(
    parameter int W     = 9,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             add_en,
    input  logic [INC_W-1:0] add,
    output logic [W-1:0]     cnt
);
    logic [W-1:0] base;
    logic [W:0]   sum;
    logic [W-1:0] nxt;

    always_comb begin
        base = clr ? '0 : cnt;
        sum  = {1'b0, base} + (add_en ? (W+1)'(add) : '0);
        nxt  = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr || add_en)
            cnt <= nxt;
    end
endmodule

module decompose_hint_mem #(
    parameter int NUM_POLY      = 8,
    parameter int ADDR_PER_POLY = 64,
    parameter int DATA_WIDTH    = 4,
    parameter int OMEGA         = 75,
    localparam int ADDR_WIDTH   = $clog2(NUM_POLY*ADDR_PER_POLY),
    localparam int PSEL_W       = $clog2(NUM_POLY),
    localparam int PCNT_W       = $clog2(ADDR_PER_POLY*DATA_WIDTH+1),
    localparam int TCNT_W       = $clog2(NUM_POLY*ADDR_PER_POLY*DATA_WIDTH+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  zeroize,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  cnt_clr,
    input  logic [PSEL_W-1:0]     cnt_poly_sel,
    output logic [PCNT_W-1:0]     poly_cnt,
    output logic [TCNT_W-1:0]     total_cnt,
    output logic                  omega_exceeded,
    output logic                  busy
);
    localparam int MEM_DEPTH = NUM_POLY*ADDR_PER_POLY;
    localparam int POFF_W    = $clog2(ADDR_PER_POLY);
    localparam int PIDX_W    = ADDR_WIDTH - POFF_W;
    localparam int POP_W     = $clog2(DATA_WIDTH+1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  restart;
    logic                  wr_in_range, rd_in_range, sw_in_range;
    logic                  wr_ok, byp;

    assign restart = reset | zeroize;
    assign busy    = (state == S_SWEEP);

    always_ff @(posedge clk) begin
        if (restart) begin
            state      <= S_SWEEP;
            sweep_addr <= '0;
        end else if (state == S_SWEEP) begin
            sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
            if (sweep_addr == '1)
                state <= S_IDLE;
        end
    end

    // Addresses past the last poly exist only when NUM_POLY is not a power of two.
    if (MEM_DEPTH == 2**ADDR_WIDTH) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
        assign sw_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH-1);
        assign wr_in_range = (wr_addr <= LAST);
        assign rd_in_range = (rd_addr <= LAST);
        assign sw_in_range = (sweep_addr <= LAST);
    end

    assign wr_ok = wr_en && !busy && !restart && wr_in_range;

    // Single write port shared by the sweep and the decompose writer.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (busy) begin
            mem_we    = !restart && sw_in_range;
            mem_waddr = sweep_addr;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

`ifdef DECOMPOSE_HINT_MEM_RDBYPASS_EN
    assign byp = wr_ok && (wr_addr == rd_addr);
`else
    assign byp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (restart)
            rd_data <= '0;
        else if (rd_en) begin
            if (busy || !rd_in_range)
                rd_data <= '0;
            else if (byp)
                rd_data <= wr_data;
            else
                rd_data <= mem[rd_addr];
        end
    end

    // Popcount counters: track ones written, not current contents.
    logic [PIDX_W-1:0]                wr_poly;
    logic [POP_W-1:0]                 wr_pop;
    logic [NUM_POLY-1:0]              poly_add;
    logic [NUM_POLY-1:0][PCNT_W-1:0]  poly_cnt_q;
    logic                             clr_ok;

    assign wr_poly = wr_addr[ADDR_WIDTH-1:POFF_W];
    assign clr_ok  = cnt_clr && !busy;

    always_comb begin
        wr_pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            wr_pop = wr_pop + POP_W'(wr_data[i]);
    end

    for (genvar g = 0; g < NUM_POLY; g++) begin : g_poly
        assign poly_add[g] = wr_ok && (wr_poly == PIDX_W'(g));
        hint_sat_cnt #(.W(PCNT_W), .INC_W(POP_W)) u_cnt (
            .clk    (clk),
            .reset  (restart),
            .clr    (clr_ok),
            .add_en (poly_add[g]),
            .add    (wr_pop),
            .cnt    (poly_cnt_q[g])
        );
    end

    hint_sat_cnt #(.W(TCNT_W), .INC_W(POP_W)) u_total (
        .clk    (clk),
        .reset  (restart),
        .clr    (clr_ok),
        .add_en (wr_ok),
        .add    (wr_pop),
        .cnt    (total_cnt)
    );

    if (NUM_POLY == 2**PSEL_W) begin : g_sel_pow2
        assign poly_cnt = poly_cnt_q[cnt_poly_sel];
    end else begin : g_sel_npow2
        assign poly_cnt = (cnt_poly_sel <= PSEL_W'(NUM_POLY-1)) ? poly_cnt_q[cnt_poly_sel] : '0;
    end

    assign omega_exceeded = (total_cnt > TCNT_W'(OMEGA));
endmodule

// File: tb/tb_decompose_hint_mem.sv
// Scoreboard bench for decompose_hint_mem: stimulus queues expectations, monitor compares.
module tb_decompose_hint_mem;
    localparam int AW = 9, DW = 4, PSW = 3, PCW = 9, TCW = 12;

    logic           clk = 1'b0;
    logic           reset, zeroize, wr_en, rd_en, cnt_clr;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [DW-1:0]  wr_data, rd_data;
    logic [PSW-1:0] cnt_poly_sel;
    logic [PCW-1:0] poly_cnt;
    logic [TCW-1:0] total_cnt;
    logic           omega_exceeded, busy;

    decompose_hint_mem dut (
        .clk(clk), .reset(reset), .zeroize(zeroize),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cnt_clr(cnt_clr), .cnt_poly_sel(cnt_poly_sel),
        .poly_cnt(poly_cnt), .total_cnt(total_cnt),
        .omega_exceeded(omega_exceeded), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int p; int t; int o; } cnt_exp_t;

    int       checks = 0, errors = 0;
    int       rd_q[$];
    cnt_exp_t cnt_q[$];
    logic     cnt_chk = 1'b0;
    logic     rd_pend = 1'b0;
    logic     last_busy;
    logic     armed = 1'b0;
    int       bcount = 0, busy_rd_nz = 0;

`ifdef DECOMPOSE_HINT_MEM_RDBYPASS_EN
    localparam int BYP_EXP = 'hA;
`else
    localparam int BYP_EXP = 'h5;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_en;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) check("rd_q_underflow", 1, 0);
            else check("rd_data", int'(rd_data), rd_q.pop_front());
        end
        if (cnt_chk) begin
            if (cnt_q.size() == 0) check("cnt_q_underflow", 1, 0);
            else begin
                cnt_exp_t e;
                e = cnt_q.pop_front();
                check("poly_cnt", int'(poly_cnt), e.p);
                check("total_cnt", int'(total_cnt), e.t);
                check("omega_exceeded", int'(omega_exceeded), e.o);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        last_busy = busy;
        if (busy) bcount++;
        if (armed && busy && !reset && rd_data != '0) busy_rd_nz++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        wr_en = 1'b0; rd_en = 1'b0; cnt_chk = 1'b0; cnt_clr = 1'b0; zeroize = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    endtask

    task automatic rd(input int a, input int e);
        rd_en = 1'b1; rd_addr = AW'(a); rd_q.push_back(e);
    endtask

    task automatic chk(input int sel, input int p, input int t, input int o);
        cnt_exp_t e;
        e.p = p; e.t = t; e.o = o;
        cnt_chk = 1'b1; cnt_poly_sel = PSW'(sel); cnt_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int exp);
        int g = 0;
        do begin step(); g++; end while (last_busy && g < 4000);
        if (last_busy) check("idle_timeout", 1, 0);
        check(name, bcount, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; zeroize = 1'b0; wr_en = 1'b0; rd_en = 1'b0; cnt_clr = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; cnt_poly_sel = '0;
        @(posedge clk); #1;
        step();
        reset = 1'b0; bcount = 0; armed = 1'b1;
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_poly_cnt", int'(poly_cnt), 0);
        check("rst_total_cnt", int'(total_cnt), 0);
        check("rst_omega", int'(omega_exceeded), 0);
        wait_idle("sweep_len_reset", 512);

        // post-sweep reads return zero
        rd('h041, 0); chk(0, 0, 0, 0); step();
        rd('h1FF, 0); step();

        // basic write, read next cycle, counters one cycle later
        wr('h041, 'hB); step();
        rd('h041, 'hB); chk(1, 3, 3, 0); step();

        // omega boundary: 19 x 0xF into poly 2
        cnt_clr = 1'b1; step();
        for (int i = 0; i < 19; i++) begin
            wr('h080 + i, 'hF);
            if (i > 0) chk(2, 4*i, 4*i, (4*i > 75) ? 1 : 0);
            step();
        end
        chk(2, 76, 76, 1); step();
        cnt_clr = 1'b1; step();
        chk(2, 0, 0, 0); step();

        // cnt_clr together with a write
        wr('h141, 'hF); step();
        chk(5, 4, 4, 0); step();
        cnt_clr = 1'b1; wr('h140, 'h7); step();
        chk(5, 3, 3, 0); step();
        chk(2, 0, 3, 0); step();

        // same-cycle read/write to one address
        wr('h100, 'h5); step();
        wr('h100, 'hA); rd('h100, BYP_EXP); step();
        rd('h100, 'hA); chk(4, 4, 7, 0); step();
        chk(5, 3, 7, 0); step();

        // poly counter saturation: 512 ones into a 9-bit counter
        cnt_clr = 1'b1; step();
        for (int i = 0; i < 128; i++) begin
            wr(i % 64, 'hF); step();
        end
        chk(0, 511, 512, 1); step();

        // zeroize, restart mid-sweep twice, writes while busy are dropped
        zeroize = 1'b1; step();
        bcount = 0;
        rd('h041, 0); chk(0, 0, 0, 0); step();
        repeat (198) step();
        zeroize = 1'b1; step();
        bcount = 0;
        repeat (100) step();
        zeroize = 1'b1; step();
        bcount = 0;
        repeat (20) step();
        wr('h010, 'hF); step();
        rd('h100, 0); chk(0, 0, 0, 0); step();
        wait_idle("sweep_len_zeroize", 512);
        rd('h010, 0); chk(0, 0, 0, 0); step();
        rd('h041, 0); step();
        rd('h100, 0); step();
        step(); step();

        check("rd_q_drained", rd_q.size(), 0);
        check("cnt_q_drained", cnt_q.size(), 0);
        check("rd_zero_while_busy", busy_rd_nz, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
